// File: rtl/cpu_pkg.sv
// cpu_pkg: shared machine-state encodings, control-flow opcodes and default widths
package cpu_pkg;
  localparam int ADDR_W_DEFAULT = 8;
  localparam logic [2:0] ST_FETCH   = 3'b000;
  localparam logic [2:0] ST_DECODE  = 3'b001;
  localparam logic [2:0] ST_EXECUTE = 3'b010;
  localparam logic [2:0] ST_HALT    = 3'b100;
  localparam logic [1:0] TYPE_CTRL  = 2'b11;
  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_JZ   = 3'b001;
  localparam logic [2:0] OP_JNZ  = 3'b010;
  localparam logic [2:0] OP_JC   = 3'b011;
  localparam logic [2:0] OP_JNC  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
endpackage

// File: rtl/call_stack.sv
// call_stack: return-address LIFO of ADDR_W-bit entries with full/empty status
module call_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     top_idx;
  logic [ADDR_W-1:0] mem [DEPTH];
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign top_idx = IW'(cnt - CW'(1));
  assign dout    = mem[top_idx];
  // occupancy count; only reset clears it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (push && !full) cnt <= cnt + CW'(1);
    else if (pop && !empty) cnt <= cnt - CW'(1);
  // entry storage needs no reset, occupancy decides what is valid
  always_ff @(posedge clk)
    if (push && !full) mem[IW'(cnt)] <= din;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and FETCH/DECODE/EXECUTE sequencer; FETCH_CALL_STACK_EN adds CALL/RET return stack
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                STACK_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        instructionType,
  input  logic [2:0]        instructionCode,
  input  logic [7:0]        literalOrAddress,
  input  logic              zeroFlag,
  input  logic              carryFlag,
  input  logic              stall,
  output logic [ADDR_W-1:0] romAddress,
  output logic [2:0]        state,
  output logic              halted,
  output logic              stackFault
);
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] pc_inc, lit, next_pc, call_pc, ret_pc;
  logic              exit, is_ctrl, is_call, is_ret, call_fault, halt_now;
  assign pc_inc   = romAddress + ADDR_W'(1);
  assign lit      = ADDR_W'(literalOrAddress);
  assign is_ctrl  = instructionType == TYPE_CTRL;
  assign is_call  = is_ctrl && instructionCode == OP_CALL;
  assign is_ret   = is_ctrl && instructionCode == OP_RET;
  assign exit     = state == ST_EXECUTE && !stall;
  assign halt_now = (is_ctrl && instructionCode == OP_HALT) || call_fault;
  assign halted   = state == ST_HALT;
`ifdef FETCH_CALL_STACK_EN
  logic full, empty, push, pop;
  assign push       = exit && is_call && !full;
  assign pop        = exit && is_ret && !empty;
  assign call_fault = (is_call && full) || (is_ret && empty);
  assign call_pc    = lit;
  call_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(pc_inc), .dout(ret_pc), .full(full), .empty(empty)
  );
  // sticky fault on a CALL into a full stack or RET from an empty one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stackFault <= 1'b0;
    else if (exit && call_fault) stackFault <= 1'b1;
`else
  assign call_fault = 1'b0;
  assign call_pc    = pc_inc;
  assign ret_pc     = pc_inc;
  assign stackFault = 1'b0;
`endif
  // target of the instruction leaving EXECUTE
  always_comb begin
    next_pc = pc_inc;
    if (is_ctrl)
      case (instructionCode)
        OP_JMP:  next_pc = lit;
        OP_JZ:   next_pc = zeroFlag ? lit : pc_inc;
        OP_JNZ:  next_pc = !zeroFlag ? lit : pc_inc;
        OP_JC:   next_pc = carryFlag ? lit : pc_inc;
        OP_JNC:  next_pc = !carryFlag ? lit : pc_inc;
        OP_CALL: next_pc = call_pc;
        OP_RET:  next_pc = ret_pc;
        default: next_pc = pc_inc;
      endcase
  end
  // sequencing; unreachable codes fall back to FETCH
  always_comb begin
    case (state)
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = stall ? ST_EXECUTE : halt_now ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end
  // state and PC; PC moves only when an instruction retires without halting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_FETCH;
      romAddress <= RESET_VECTOR;
    end else begin
      state <= state_d;
      if (exit && !halt_now) romAddress <= next_pc;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed instruction stream checked against an instruction-level model every cycle
module tb_fetch_sequencer;
  localparam logic [7:0] RV = 8'h00;
`ifdef FETCH_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b1;
  logic [1:0] itype = '0;
  logic [2:0] icode = '0;
  logic [7:0] lit = '0;
  logic       z = 1'b0, c = 1'b0, stall = 1'b0;
  logic [7:0] rom;
  logic [2:0] st;
  logic       hlt, sf;
  int checks = 0, errors = 0;
  int exp_state = 0, exp_pc = 0, exp_halted = 0, exp_fault = 0;
  int stk[$];
  bit mon = 1'b0;

  fetch_sequencer #(.ADDR_W(8), .RESET_VECTOR(RV), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .instructionType(itype), .instructionCode(icode),
    .literalOrAddress(lit), .zeroFlag(z), .carryFlag(c), .stall(stall),
    .romAddress(rom), .state(st), .halted(hlt), .stackFault(sf)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (mon) begin
      chk("state", st, exp_state);
      chk("romAddress", rom, exp_pc);
      chk("halted", hlt, exp_halted);
      chk("stackFault", sf, exp_fault);
    end

  // what retiring one instruction does to the architectural state
  task automatic retire(int t, int code, int l, int zf, int cf);
    int npc = (exp_pc + 1) % 256;
    bit halt = 1'b0;
    if (t == 3)
      case (code)
        0: npc = l;
        1: if (zf != 0) npc = l;
        2: if (zf == 0) npc = l;
        3: if (cf != 0) npc = l;
        4: if (cf == 0) npc = l;
        5: if (STACK_EN) begin
             if (stk.size() >= 4) begin halt = 1'b1; exp_fault = 1; end
             else begin stk.push_back(npc); npc = l; end
           end
        6: if (STACK_EN) begin
             if (stk.size() == 0) begin halt = 1'b1; exp_fault = 1; end
             else npc = stk.pop_back();
           end
        default: halt = 1'b1;
      endcase
    if (halt) begin exp_state = 4; exp_halted = 1; end
    else begin exp_state = 0; exp_pc = npc; end
  endtask

  // one instruction from FETCH; flags hold the wrong value until the exit edge
  task automatic run(int t, int code, int l, int zf, int cf, int stalls);
    itype = 2'(t); icode = 3'(code); lit = 8'(l);
    z = !zf[0]; c = !cf[0]; stall = stalls > 0;
    @(posedge clk); #1 exp_state = 1;
    @(posedge clk); #1 exp_state = 2;
    repeat (stalls) begin @(posedge clk); #1; end
    stall = 1'b0; z = zf[0]; c = cf[0];
    @(posedge clk); #1 retire(t, code, l, zf, cf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_state = 0; exp_pc = RV; exp_halted = 0; exp_fault = 0;
    stk.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1 do_reset();
    mon = 1'b1;
    chk("reset_state", st, 0);
    chk("reset_rom", rom, 8'h00);
    chk("reset_halted", hlt, 0);
    chk("reset_fault", sf, 0);
    repeat (3) run(0, 0, 0, 0, 0, 0);
    chk("seq_pc", rom, 8'h03);
    run(3, 0, 8'h05, 0, 0, 0);
    run(3, 1, 8'h40, 0, 0, 0);
    chk("jz_not_taken", rom, 8'h06);
    run(3, 0, 8'h05, 0, 0, 0);
    run(3, 1, 8'h40, 1, 0, 2);
    chk("jz_taken", rom, 8'h40);
    run(3, 2, 8'h50, 0, 0, 0);
    run(3, 3, 8'h60, 0, 0, 0);
    chk("jc_not_taken", rom, 8'h51);
    run(3, 4, 8'h70, 0, 0, 0);
    chk("jnc_taken", rom, 8'h70);
    run(1, 0, 0, 0, 0, 4);
    chk("stall_pc", rom, 8'h71);
    run(3, 0, 8'hFF, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0);
    chk("wrap", rom, 8'h00);
    run(3, 0, 8'h10, 0, 0, 0);
    run(3, 5, 8'h20, 0, 0, 0);
    chk("call", rom, STACK_EN ? 8'h20 : 8'h11);
    run(3, 6, 0, 0, 0, 0);
    chk("ret", rom, STACK_EN ? 8'h11 : 8'h12);
    for (int i = 0; i < 5; i++) run(3, 5, 8'h30 + i, 0, 0, 0);
    chk("nest_rom", rom, STACK_EN ? 8'h33 : 8'h17);
    chk("nest_fault", sf, STACK_EN ? 1 : 0);
    chk("nest_halted", hlt, STACK_EN ? 1 : 0);
    do_reset();
    run(3, 6, 0, 0, 0, 0);
    chk("ret_empty_fault", sf, STACK_EN ? 1 : 0);
    do_reset();
    run(3, 0, 8'h12, 0, 0, 0);
    itype = 2'b00; icode = 3'b000;
    @(posedge clk); #1 exp_state = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", st, 0);
    chk("async_rom", rom, 8'h00);
    do_reset();
    run(3, 0, 8'h2A, 0, 0, 0);
    run(3, 7, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      stall = 1'($urandom); z = 1'($urandom); c = 1'($urandom);
    end
    chk("halt_state", st, 3'b100);
    chk("halt_flag", hlt, 1);
    chk("halt_rom", rom, 8'h2A);
    @(negedge clk);
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
